// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period and high time of an asynchronous PWM input and
// reports duty cycle in permille through a restoring divider, plus a stuck-line timeout.
// Ports: clk, rst (async, active-high), pwm_in (async PWM), duty (permille 0..1000),
// period (clk cycles, 0 after a timeout), duty_valid (1-cycle update strobe),
// stuck (last result was a timeout), overrun (sticky: period dropped while dividing).
// Optional macro PWM_DUTY_METER_DEGLITCH_EN inserts a FILT_LEN-sample stability filter.
module pwm_duty_meter #(
  parameter int CNT_W    = 20,
  parameter int TIMEOUT  = 200000,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [9:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic             duty_valid,
  output logic             stuck,
  output logic             overrun
);
  localparam int NW = CNT_W + 10;
  localparam int DW = $clog2(NW);
  if (longint'(TIMEOUT) >= (64'd1 << CNT_W) || FILT_LEN < 1) begin : g_bad_cfg
    $error("pwm_duty_meter: TIMEOUT must be < 2**CNT_W and FILT_LEN >= 1");
  end
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t           state_q;
  logic             s1_q, s2_q, prev_q, lvl, rise, fall, tout, busy_q, ge, last;
  logic [CNT_W-1:0] cnt_q, high_q, den_q, rem_q, rem_d;
  logic [CNT_W:0]   trial;
  logic [NW-1:0]    nq_q, nq_d;
  logic [DW-1:0]    dcnt_q;
  logic [9:0]       qsat;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= pwm_in;
      s2_q   <= s1_q;
      prev_q <= lvl;
    end
  end
`ifdef PWM_DUTY_METER_DEGLITCH_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  // the filtered level follows only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (s2_q == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FW'(FILT_LEN - 1)) begin
      filt_q <= s2_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end
  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif
  always_comb begin
    rise  = lvl & ~prev_q;
    fall  = ~lvl & prev_q;
    // a rising strobe in the timeout cycle takes precedence
    tout  = (cnt_q == CNT_W'(TIMEOUT - 1)) & ~rise;
    trial = {rem_q, nq_q[NW-1]};
    ge    = trial >= {1'b0, den_q};
    // when not ge, trial < den so its top bit is already zero
    rem_d = ge ? CNT_W'(trial - {1'b0, den_q}) : trial[CNT_W-1:0];
    nq_d  = {nq_q[NW-2:0], ge};
    qsat  = (nq_d > NW'(1000)) ? 10'd1000 : nq_d[9:0];
    last  = busy_q & (dcnt_q == DW'(NW - 1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_q     <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      nq_q       <= '0;
      dcnt_q     <= '0;
      busy_q     <= 1'b0;
      duty       <= '0;
      period     <= '0;
      duty_valid <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      cnt_q      <= (rise | tout) ? '0 : cnt_q + 1'b1;
      if (tout) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        duty       <= lvl ? 10'd1000 : 10'd0;
        period     <= '0;
        stuck      <= 1'b1;
        duty_valid <= 1'b1;
      end else begin
        if (busy_q) begin
          rem_q  <= rem_d;
          nq_q   <= nq_d;
          dcnt_q <= dcnt_q + 1'b1;
        end
        if (last) begin
          busy_q     <= 1'b0;
          duty       <= qsat;
          period     <= den_q;
          stuck      <= 1'b0;
          duty_valid <= 1'b1;
        end
        case (state_q)
          IDLE: if (rise) state_q <= HIGH;
          HIGH: if (fall) begin
            high_q  <= cnt_q + 1'b1;
            state_q <= LOW;
          end
          LOW: if (rise) begin
            state_q <= HIGH;
            // a divider finishing this cycle is free to take the new period
            if (busy_q && !last) begin
              overrun <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              rem_q  <= '0;
              nq_q   <= NW'(high_q) * NW'(1000);
              den_q  <= cnt_q + 1'b1;
              dcnt_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: directed PWM waveforms with a result scoreboard for pwm_duty_meter.
module tb_pwm_duty_meter;
  localparam int CNT_W = 20;
  localparam int TOUT  = 2000;
  logic             clk = 1'b0, rst = 1'b1, pwm_in = 1'b0;
  logic [9:0]       duty;
  logic [CNT_W-1:0] period;
  logic             duty_valid, stuck, overrun;
  int               errors = 0, checks = 0;
  typedef struct {int d; int p; int s;} exp_t;
  exp_t q[$];
  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TOUT), .FILT_LEN(4)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty(duty), .period(period),
    .duty_valid(duty_valid), .stuck(stuck), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push(input int d, input int p, input int s);
    exp_t e;
    e.d = d;
    e.p = p;
    e.s = s;
    q.push_back(e);
  endtask
  task automatic hold(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_duty"}, int'(duty), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_valid"}, int'(duty_valid), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask
  always @(negedge clk) begin
    if (duty_valid) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got duty=%0d period=%0d stuck=%0d expected none", duty, period, stuck);
      end else begin
        e = q.pop_front();
        if (int'(duty) != e.d || int'(period) != e.p || int'(stuck) != e.s) begin
          errors++;
          $display("FAIL result: got duty=%0d period=%0d stuck=%0d expected duty=%0d period=%0d stuck=%0d",
                   duty, period, stuck, e.d, e.p, e.s);
        end
      end
    end
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    // 25/75 periodic waveform, then latency of the terminating edge
    for (int i = 0; i < 4; i++) begin
      if (i > 0) push(250, 100, 0);
      hold(1'b1, 25);
      hold(1'b0, 75);
    end
    push(250, 100, 0);
    pwm_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!duty_valid && n < 100);
`ifdef PWM_DUTY_METER_DEGLITCH_EN
    chk("valid_latency", n, 37);
`else
    chk("valid_latency", n, 33);
`endif
    // reset while a division is in flight and the FSM is in HIGH
    hold(1'b0, 67);
    hold(1'b1, 10);
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    @(negedge clk);
    pwm_in = 1'b0;
    rst = 1'b0;
    hold(1'b0, 5);
    // two fresh edges before any result, then glitches on a 40/60 waveform
    hold(1'b1, 40);
    hold(1'b0, 60);
    push(400, 100, 0);
    hold(1'b1, 40);
    hold(1'b0, 60);
    push(400, 100, 0);
    hold(1'b1, 40);
    hold(1'b0, 60);
    push(400, 100, 0);
    hold(1'b1, 20);
    hold(1'b0, 2);
    hold(1'b1, 18);
    hold(1'b0, 60);
`ifdef PWM_DUTY_METER_DEGLITCH_EN
    push(400, 100, 0);
`else
    // the glitch rise lands while dividing and is dropped; 18/78 is measured next
    push(230, 78, 0);
`endif
    hold(1'b1, 40);
    hold(1'b0, 60);
    // line stuck high: timeout repeats every TOUT cycles
    pwm_in = 1'b1;
    do_reset();
    push(1000, 0, 1);
    push(1000, 0, 1);
    hold(1'b1, 2 * TOUT + 100);
    // line stuck low, then a real waveform clears stuck
    pwm_in = 1'b0;
    do_reset();
    push(0, 0, 1);
    hold(1'b0, TOUT + 50);
    hold(1'b1, 40);
    hold(1'b0, 60);
    push(400, 100, 0);
    hold(1'b1, 40);
    hold(1'b0, 60);
`ifndef PWM_DUTY_METER_DEGLITCH_EN
    // extreme duties: 1/999 and 999/1
    pwm_in = 1'b0;
    do_reset();
    hold(1'b1, 1);
    hold(1'b0, 999);
    push(1, 1000, 0);
    hold(1'b1, 1);
    hold(1'b0, 999);
    push(1, 1000, 0);
    hold(1'b1, 999);
    hold(1'b0, 1);
    push(999, 1000, 0);
    hold(1'b1, 999);
    hold(1'b0, 1);
    push(999, 1000, 0);
    hold(1'b1, 5);
    hold(1'b0, 50);
`endif
    // 20-cycle period is shorter than the divide: every other period is dropped
    pwm_in = 1'b0;
    do_reset();
    chk("overrun_clear", int'(overrun), 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 1 || i == 3 || i == 5) push(250, 20, 0);
      hold(1'b1, 5);
      hold(1'b0, 15);
    end
    hold(1'b0, 60);
    chk("overrun_set", int'(overrun), 1);
    hold(1'b0, 100);
    chk("overrun_sticky", int'(overrun), 1);
    chk("results_pending", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
